// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, price/stock checks, dispense
// handshake and 10-unit change return. All outputs are registered.
module vend_controller #(
  parameter int PRICE_CHOC = 10,
  parameter int PRICE_ICE  = 20,
  parameter int PRICE_COLD = 50,
  parameter int CREDIT_MAX = 60,
  parameter int STOCK_INIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin,
  input  logic       sel_valid,
  input  logic [1:0] select,
  input  logic       cancel,
  input  logic       restock,
  input  logic       vend_done,
  output logic       vend_req,
  output logic [1:0] vend_item,
  output logic       change_pulse,
  output logic [5:0] credit,
  output logic       coin_reject,
  output logic       sel_reject,
  output logic [2:0] sold_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam logic [3:0] STOCK_RST = 4'(STOCK_INIT);
  localparam logic [6:0] CMAX      = 7'(CREDIT_MAX);
  localparam logic [7:0] TMO       = 8'(TIMEOUT);

  state_t     state, state_n;
  logic [3:0] stock   [3];
  logic [3:0] stock_n [3];
  logic [7:0] tcount, tcount_n;
  logic [5:0] credit_n;
  logic       vend_req_n, coin_reject_n, sel_reject_n;
  logic [1:0] vend_item_n;
  logic [5:0] coin_val, price;
  logic [6:0] coin_sum;
  logic [3:0] stock_sel;
  logic       coin_fits, sel_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      tcount       <= '0;
      stock        <= '{STOCK_RST, STOCK_RST, STOCK_RST};
      vend_req     <= 1'b0;
      vend_item    <= 2'b00;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      sold_out     <= 3'b000;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      tcount       <= tcount_n;
      stock        <= stock_n;
      vend_req     <= vend_req_n;
      vend_item    <= vend_item_n;
      change_pulse <= (state_n == CHANGE);
      coin_reject  <= coin_reject_n;
      sel_reject   <= sel_reject_n;
      sold_out     <= {stock_n[2] == 4'd0, stock_n[1] == 4'd0, stock_n[0] == 4'd0};
      busy         <= (state_n == VEND) || (state_n == CHANGE);
    end
  end

  always_comb begin
    coin_val = 6'd0;
    case (coin)
      2'b00:   coin_val = 6'd10;
      2'b01:   coin_val = 6'd20;
      2'b10:   coin_val = 6'd50;
      default: coin_val = 6'd0;
    endcase
    price     = 6'd0;
    stock_sel = 4'd0;
    case (select)
      2'b00:   begin price = 6'(PRICE_CHOC); stock_sel = stock[0]; end
      2'b01:   begin price = 6'(PRICE_ICE);  stock_sel = stock[1]; end
      2'b10:   begin price = 6'(PRICE_COLD); stock_sel = stock[2]; end
      default: begin price = 6'd0;           stock_sel = 4'd0;     end
    endcase
    coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    coin_fits = (coin != 2'b11) && (coin_sum <= CMAX);
    sel_ok    = (select != 2'b11) && (stock_sel != 4'd0) && (credit >= price);
  end

  // Next state, credit, stock and pulse outputs; priority cancel > select > coin.
  always_comb begin
    state_n       = state;
    credit_n      = credit;
    stock_n       = stock;
    tcount_n      = tcount;
    vend_req_n    = vend_req;
    vend_item_n   = vend_item;
    coin_reject_n = 1'b0;
    sel_reject_n  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          sel_reject_n  = 1'b1;
          coin_reject_n = coin_valid;
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_n = coin_sum[5:0];
            tcount_n = 8'd0;
            state_n  = CREDIT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end
        if (restock) stock_n = '{STOCK_RST, STOCK_RST, STOCK_RST};
      end
      CREDIT: begin
        if (cancel) begin
          coin_reject_n = coin_valid;
          state_n       = CHANGE;
        end else if (sel_valid) begin
          coin_reject_n = coin_valid;
          if (sel_ok) begin
            credit_n    = credit - price;
            vend_item_n = select;
            vend_req_n  = 1'b1;
            state_n     = VEND;
            for (int i = 0; i < 3; i++)
              if (select == 2'(i)) stock_n[i] = stock[i] - 4'd1;
          end else begin
            sel_reject_n = 1'b1;
            tcount_n     = 8'd0;
          end
        end else if (coin_valid && coin_fits) begin
          credit_n = coin_sum[5:0];
          tcount_n = 8'd0;
        end else begin
          coin_reject_n = coin_valid;
          tcount_n      = tcount + 8'd1;
          if (tcount + 8'd1 == TMO) state_n = CHANGE;
        end
      end
      VEND: begin
        coin_reject_n = coin_valid;
        sel_reject_n  = sel_valid;
        if (vend_done) begin
          vend_req_n  = 1'b0;
          vend_item_n = 2'b00;
          state_n     = (credit != 6'd0) ? CHANGE : IDLE;
        end
      end
      default: begin
        // Each CHANGE cycle carries one pulse; credit shows the amount still owed.
        coin_reject_n = coin_valid;
        sel_reject_n  = sel_valid;
        credit_n      = (credit >= 6'd10) ? credit - 6'd10 : 6'd0;
        if (credit <= 6'd10) state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller; change pulses are checked against
// a queue of expected credit values pushed when the refund is triggered.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset, coin_valid, sel_valid, cancel, restock, vend_done;
  logic [1:0] coin, select;
  logic       vend_req, change_pulse, coin_reject, sel_reject, busy;
  logic [1:0] vend_item;
  logic [5:0] credit;
  logic [2:0] sold_out;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  vend_controller dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .select(select), .cancel(cancel), .restock(restock),
    .vend_done(vend_done), .vend_req(vend_req), .vend_item(vend_item),
    .change_pulse(change_pulse), .credit(credit), .coin_reject(coin_reject),
    .sel_reject(sel_reject), .sold_out(sold_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin       = code;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic do_sel(input logic [1:0] code);
    sel_valid = 1'b1;
    select    = code;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (credit !== 6'd0) begin n_bad++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    do_coin(2'b01);
    do_sel(2'b00);
    n_cmp++; if (vend_req !== 1'b1) begin n_bad++; $display("FAIL pre_reset_vend_req: got %b want 1", vend_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({vend_req, busy, change_pulse} !== 3'b000)
      begin n_bad++; $display("FAIL midvend_reset_flags: got %b want 000", {vend_req, busy, change_pulse}); end
    n_cmp++; if (credit !== 6'd0) begin n_bad++; $display("FAIL midvend_reset_credit: got %0d want 0", credit); end
    n_cmp++; if (sold_out !== 3'b000) begin n_bad++; $display("FAIL midvend_reset_sold_out: got %b want 000", sold_out); end
    tick();
    n_cmp++; if (change_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_no_refund: got %b want 0", change_pulse); end
  endtask

  task automatic test_vend_change();
    int n, got;
    do_coin(2'b01);
    do_coin(2'b01);
    n_cmp++; if (credit !== 6'd40) begin n_bad++; $display("FAIL vc_credit40: got %0d want 40", credit); end
    do_sel(2'b01);
    exp_q.push_back(20);
    exp_q.push_back(10);
    n_cmp++; if ({vend_req, vend_item, busy} !== 4'b1011)
      begin n_bad++; $display("FAIL vc_vend: got %b want 1011", {vend_req, vend_item, busy}); end
    n_cmp++; if (credit !== 6'd20) begin n_bad++; $display("FAIL vc_credit20: got %0d want 20", credit); end
    tick(); tick();
    n_cmp++; if (vend_req !== 1'b1) begin n_bad++; $display("FAIL vc_hold: got %b want 1", vend_req); end
    vend_done = 1'b1;
    tick();
    vend_done = 1'b0;
    n_cmp++; if (vend_req !== 1'b0) begin n_bad++; $display("FAIL vc_req_drop: got %b want 0", vend_req); end
    n = 0;
    while (change_pulse === 1'b1 && n < 10) begin
      got = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (int'(credit) !== got) begin n_bad++; $display("FAIL vc_pulse_credit: got %0d want %0d", credit, got); end
      n++;
      tick();
    end
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL vc_pulse_count: got %0d want 2", n); end
    n_cmp++; if ({credit, busy} !== 7'd0) begin n_bad++; $display("FAIL vc_idle: got credit %0d busy %b want 0 0", credit, busy); end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int n, got;
    do_coin(2'b00);
    do_sel(2'b10);
    n_cmp++; if (sel_reject !== 1'b1) begin n_bad++; $display("FAIL to_sel_reject: got %b want 1", sel_reject); end
    n_cmp++; if (credit !== 6'd10) begin n_bad++; $display("FAIL to_credit: got %0d want 10", credit); end
    exp_q.push_back(10);
    n = 0;
    while (change_pulse !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 255) begin n_bad++; $display("FAIL to_cycles: got %0d want 255", n); end
    n = 0;
    while (change_pulse === 1'b1 && n < 10) begin
      got = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (int'(credit) !== got) begin n_bad++; $display("FAIL to_pulse_credit: got %0d want %0d", credit, got); end
      n++;
      tick();
    end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL to_pulse_count: got %0d want 1", n); end
    n_cmp++; if ({credit, busy} !== 7'd0) begin n_bad++; $display("FAIL to_idle: got credit %0d busy %b want 0 0", credit, busy); end
    exp_q.delete();
  endtask

  task automatic test_coin_overflow();
    int n, got;
    do_coin(2'b10);
    n_cmp++; if (credit !== 6'd50) begin n_bad++; $display("FAIL ov_credit50: got %0d want 50", credit); end
    do_coin(2'b01);
    n_cmp++; if (coin_reject !== 1'b1) begin n_bad++; $display("FAIL ov_reject: got %b want 1", coin_reject); end
    n_cmp++; if (credit !== 6'd50) begin n_bad++; $display("FAIL ov_credit_kept: got %0d want 50", credit); end
    for (int v = 50; v > 0; v -= 10) exp_q.push_back(v);
    cancel = 1'b1;
    do_coin(2'b00);
    cancel = 1'b0;
    n_cmp++; if (coin_reject !== 1'b1) begin n_bad++; $display("FAIL ov_cancel_coin_reject: got %b want 1", coin_reject); end
    n = 0;
    while (change_pulse === 1'b1 && n < 10) begin
      got = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (int'(credit) !== got) begin n_bad++; $display("FAIL ov_pulse_credit: got %0d want %0d", credit, got); end
      n++;
      tick();
    end
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL ov_pulse_count: got %0d want 5", n); end
    exp_q.delete();
  endtask

  task automatic test_stock();
    int n;
    for (int k = 0; k < 4; k++) begin
      do_coin(2'b00);
      do_sel(2'b00);
      n_cmp++; if (vend_req !== 1'b1) begin n_bad++; $display("FAIL st_vend_%0d: got %b want 1", k, vend_req); end
      vend_done = 1'b1;
      tick();
      vend_done = 1'b0;
      n_cmp++; if ({vend_req, busy, change_pulse} !== 3'b000)
        begin n_bad++; $display("FAIL st_done_%0d: got %b want 000", k, {vend_req, busy, change_pulse}); end
    end
    n_cmp++; if (sold_out !== 3'b001) begin n_bad++; $display("FAIL st_sold_out: got %b want 001", sold_out); end
    do_coin(2'b00);
    do_sel(2'b00);
    n_cmp++; if ({sel_reject, vend_req} !== 2'b10) begin n_bad++; $display("FAIL st_fifth: got %b want 10", {sel_reject, vend_req}); end
    n_cmp++; if (credit !== 6'd10) begin n_bad++; $display("FAIL st_credit: got %0d want 10", credit); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n = 0;
    while (change_pulse === 1'b1 && n < 10) begin n++; tick(); end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL st_pulse_count: got %0d want 1", n); end
    restock = 1'b1;
    tick();
    restock = 1'b0;
    n_cmp++; if (sold_out !== 3'b000) begin n_bad++; $display("FAIL st_restock: got %b want 000", sold_out); end
  endtask

  task automatic test_cancel();
    int n, got;
    logic saw_req;
    do_coin(2'b00);
    do_coin(2'b01);
    n_cmp++; if (credit !== 6'd30) begin n_bad++; $display("FAIL cn_credit30: got %0d want 30", credit); end
    for (int v = 30; v > 0; v -= 10) exp_q.push_back(v);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n = 0;
    saw_req = 1'b0;
    while (change_pulse === 1'b1 && n < 10) begin
      got = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      n_cmp++; if (int'(credit) !== got) begin n_bad++; $display("FAIL cn_pulse_credit: got %0d want %0d", credit, got); end
      saw_req |= vend_req;
      n++;
      tick();
    end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL cn_pulse_count: got %0d want 3", n); end
    n_cmp++; if (saw_req !== 1'b0) begin n_bad++; $display("FAIL cn_vend_req: got %b want 0", saw_req); end
    n_cmp++; if ({credit, busy} !== 7'd0) begin n_bad++; $display("FAIL cn_idle: got credit %0d busy %b want 0 0", credit, busy); end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin = 2'b00; sel_valid = 1'b0; select = 2'b00;
    cancel = 1'b0; restock = 1'b0; vend_done = 1'b0;
    test_reset();
    test_vend_change();
    test_timeout();
    test_coin_overflow();
    test_stock();
    test_cancel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
